seq_detector_prog: RTL

//  Runtime-programmable serial pattern detector; successor to the fixed 11-bit detector FSM.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_pat_cmp.sv | 24 ++
 rtl/seq_detector_prog.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// Holds the FSM encoding, the legacy 11-bit pattern and elaboration-time helpers.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int          LEGACY_LEN = 11;
    localparam logic [15:0] LEGACY_PAT = 16'h0650;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic bit max_len_ok(input int max_len, input int def_len);
        return (max_len >= 2) && (def_len >= 1) && (max_len >= def_len);
    endfunction

endpackage

// File: rtl/seq_pat_cmp.sv
// Combinational masked compare: hit when the low len bits of hist equal those of pat.
// Bits at or above len are ignored, so callers may store an unmasked pattern.
module seq_pat_cmp #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector, reset to the legacy 11-bit pattern.
// Optional saturating match counter is built only when SEQ_MATCH_CNT_EN is defined.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int                 MAX_LEN = 16,
    parameter  int                 DEF_LEN = LEGACY_LEN,
    parameter  logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(LEGACY_PAT),
    parameter  int                 CNT_W   = 8,
    localparam int                 LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq,
    input  logic               seq_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               tick,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    if (!max_len_ok(MAX_LEN, DEF_LEN)) begin : g_bad_cfg
        $error("seq_detector_prog: MAX_LEN must be >= DEF_LEN and >= 2");
    end

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_next;
    logic               tick_q;
    logic               cfg_err_q;
    logic               hit;
    logic               accept;
    logic               load_ok;
    logic               match;
    logic               unused_hist_msb;

    // A load on the same edge as a valid bit always wins; the bit is dropped.
    assign accept    = seq_valid && !pat_load;
    assign load_ok   = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign hist_next = {hist_q[MAX_LEN-2:0], seq};
    assign fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    assign match     = accept && hit && (fill_next >= len_q);

    assign unused_hist_msb = hist_q[MAX_LEN-1];

    seq_pat_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist (hist_next),
        .pat  (pat_q),
        .len  (len_q),
        .hit  (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q     <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= FILL;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            tick_q    <= match;
            cfg_err_q <= pat_load && !load_ok;
            if (pat_load) begin
                if (load_ok) begin
                    pat_q   <= pat_data;
                    len_q   <= pat_len;
                    fill_q  <= '0;
                    state_q <= FILL;
                end
            end else if (seq_valid) begin
                hist_q <= hist_next;
                // Non-overlap: clearing fill forces len fresh bits before the next match.
                if (match && !overlap_en) begin
                    fill_q  <= '0;
                    state_q <= FILL;
                end else begin
                    fill_q <= fill_next;
                    if (fill_next >= len_q) begin
                        state_q <= ARMED;
                    end
                end
            end
        end
    end

    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == ARMED);

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear takes priority but a same-edge match still counts as the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
